// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the four hex digits shown on a multiplexed,
// active-low 7-segment display by watching the anode and segment buses.
// A digit is captured once {an,seg} has held for STABLE_CYCLES clocks.
// After all four digits are captured, the frame is published in one step.
// Optional feature: define SEG_SCAN_ERR_COUNT_EN to add a saturating
// err_count output that counts captures of unknown patterns.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  invalid,
`ifdef SEG_SCAN_ERR_COUNT_EN
  output logic [7:0]  err_count,
`endif
  output logic        frame_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  // Counter value that, combined with one more matching sample, completes a dwell.
  localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [10:0] prev;
  logic        same;
  logic        capture;
  logic        slot_valid;
  logic [1:0]  slot_idx;
  logic [3:0]  dec_nib;
  logic        dec_blank;
  logic        dec_unknown;
  logic [3:0]  seen;
  logic [3:0]  sh_nib [4];
  logic [3:0]  sh_blank;
  logic [3:0]  sh_invalid;

  assign same = ({an, seg} == prev);

  // A scan slot is valid only when exactly one anode is driven low.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    slot_valid = 1'b1;
    slot_idx   = 2'd0;
    case (an)
      4'b1110: slot_idx = 2'd0;
      4'b1101: slot_idx = 2'd1;
      4'b1011: slot_idx = 2'd2;
      4'b0111: slot_idx = 2'd3;
      default: slot_valid = 1'b0;
    endcase
  end

  // Active-low segment pattern to hex nibble, with blank and unknown flags.
  always_comb begin
    dec_nib     = 4'h0;
    dec_blank   = 1'b0;
    dec_unknown = 1'b0;
    case (seg)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_unknown = 1'b1;
    endcase
  end

  // Next-state logic: settle on a slot, capture once per dwell, drop to IDLE on a bad slot.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!slot_valid) begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          cnt_nxt   = 8'd1;
        end
        SETTLE: begin
          if (!same) begin
            cnt_nxt = 8'd1;
          end else if (cnt >= CAP_AT) begin
            cnt_nxt   = cnt + 8'd1;
            capture   = 1'b1;
            state_nxt = CAPTURED;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        CAPTURED: begin
          if (!same) begin
            state_nxt = SETTLE;
            cnt_nxt   = 8'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // FSM state, stability counter and last-sample register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      prev  <= 11'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= {an, seg};
    end
  end

  // Shadow slots, seen tracking, and atomic publish of a completed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow array is reset explicitly because a reset must discard partial frames.
      for (int i = 0; i < 4; i++) sh_nib[i] <= 4'h0;
      sh_blank    <= 4'h0;
      sh_invalid  <= 4'h0;
      seen        <= 4'h0;
      digits      <= 16'h0000;
      blank       <= 4'h0;
      invalid     <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= &seen;
      if (&seen) begin
        digits  <= {sh_nib[3], sh_nib[2], sh_nib[1], sh_nib[0]};
        blank   <= sh_blank;
        invalid <= sh_invalid;
        seen    <= 4'h0;
      end else if (capture) begin
        seen[slot_idx] <= 1'b1;
      end
      if (capture) begin
        sh_nib[slot_idx]     <= dec_nib;
        sh_blank[slot_idx]   <= dec_blank;
        sh_invalid[slot_idx] <= dec_unknown;
      end
    end
  end

`ifdef SEG_SCAN_ERR_COUNT_EN
  // Saturating count of captures whose pattern is not in the decode table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (capture && dec_unknown && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: directed scenarios plus random scanning,
// checked every cycle against a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  invalid;
  logic        frame_valid;
`ifdef SEG_SCAN_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .blank       (blank),
    .invalid     (invalid),
`ifdef SEG_SCAN_ERR_COUNT_EN
    .err_count   (err_count),
`endif
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fv_seen = 0;

  // Reference model: a digit is captured when the run of identical valid
  // samples reaches exactly S; a full set of four publishes one clock later.
  logic [6:0]  code_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_seen;
  logic [3:0]  m_sh [4];
  logic [3:0]  m_shb, m_shi;
  logic        m_pend;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_invalid;
  logic        m_fv;
  int          m_err;

  function automatic int slot_of(input logic [3:0] a);
    int idx = -1;
    int zeros = 0;
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) begin zeros++; idx = i; end
    return (zeros == 1) ? idx : -1;
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_seen = '0; m_shb = '0; m_shi = '0; m_pend = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = '0;
    m_digits = '0; m_blank = '0; m_invalid = '0; m_fv = 0; m_err = 0;
  endtask

  task automatic model_clock(input logic [3:0] a, input logic [6:0] s);
    int idx;
    int nib;
    if ({a, s} == m_prev) begin
      if (m_run < 100000) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev = {a, s};
    m_fv = m_pend;
    if (m_pend) begin
      m_digits = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      m_blank = m_shb; m_invalid = m_shi; m_seen = '0; m_pend = 0;
    end
    idx = slot_of(a);
    if (idx >= 0 && m_run == S) begin
      nib = -1;
      for (int i = 0; i < 16; i++) if (code_tab[i] == s) nib = i;
      m_sh[idx] = (nib >= 0) ? 4'(nib) : 4'h0;
      m_shb[idx] = (s == 7'h7F);
      m_shi[idx] = (nib < 0) && (s != 7'h7F);
      if (m_shi[idx] && m_err < 255) m_err++;
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) m_pend = 1;
    end
  endtask

  task automatic compare_outputs();
    checks++;
    if (frame_valid !== m_fv) begin
      errors++; $display("FAIL frame_valid t=%0t got=%b exp=%b", $time, frame_valid, m_fv);
    end
    checks++;
    if (digits !== m_digits) begin
      errors++; $display("FAIL digits t=%0t got=%h exp=%h", $time, digits, m_digits);
    end
    checks++;
    if (blank !== m_blank || invalid !== m_invalid) begin
      errors++; $display("FAIL flags t=%0t got blank=%b invalid=%b exp blank=%b invalid=%b",
                         $time, blank, invalid, m_blank, m_invalid);
    end
`ifdef SEG_SCAN_ERR_COUNT_EN
    checks++;
    if (err_count !== 8'(m_err)) begin
      errors++; $display("FAIL err_count t=%0t got=%0d exp=%0d", $time, err_count, m_err);
    end
`endif
    if (frame_valid === 1'b1) fv_seen++;
  endtask

  // One clock of stimulus: check state left by the last edge, drive, then advance the model.
  task automatic step(input logic [3:0] a, input logic [6:0] s);
    @(negedge clk);
    compare_outputs();
    an = a; seg = s;
    @(posedge clk);
    if (!reset) model_clock(a, s);
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) step(a, s);
  endtask

  task automatic scan4(input logic [6:0] s0, s1, s2, s3, input int n);
    dwell(an_of(0), s0, n); dwell(an_of(1), s1, n);
    dwell(an_of(2), s2, n); dwell(an_of(3), s3, n);
    dwell(4'hF, 7'h7F, 3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    compare_outputs();
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    model_reset();
    #1;
    checks++;
    if (digits !== 16'h0 || blank !== 4'h0 || invalid !== 4'h0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset digits=%h blank=%b invalid=%b fv=%b exp all zero",
                         digits, blank, invalid, frame_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_frame(input string name, input int fv0, input int n_fv,
                              input logic [15:0] d, input logic [3:0] b, input logic [3:0] iv);
    checks++;
    if (fv_seen - fv0 !== n_fv) begin
      errors++; $display("FAIL %s pulses got=%0d exp=%0d", name, fv_seen - fv0, n_fv);
    end
    checks++;
    if (digits !== d || blank !== b || invalid !== iv) begin
      errors++; $display("FAIL %s frame got=%h/%b/%b exp=%h/%b/%b", name, digits, blank, invalid, d, b, iv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; an = 4'hF; seg = 7'h7F;
    model_reset();
    do_reset();
    dwell(4'hF, 7'h7F, 3);
  endtask

  task automatic test_basic_frame();
    int fv0 = fv_seen;
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 8);
    expect_frame("basic", fv0, 1, 16'h4321, 4'h0, 4'h0);
  endtask

  task automatic test_glitch();
    int fv0;
    do_reset();
    fv0 = fv_seen;
    dwell(an_of(0), 7'h40, 3);
    dwell(an_of(0), 7'h00, 4);
    dwell(an_of(1), 7'h79, 6); dwell(an_of(2), 7'h24, 6); dwell(an_of(3), 7'h30, 6);
    dwell(4'hF, 7'h7F, 3);
    expect_frame("glitch", fv0, 1, 16'h3218, 4'h0, 4'h0);
  endtask

  task automatic test_blank_invalid();
    int fv0;
    do_reset();
    fv0 = fv_seen;
    scan4(7'h0E, 7'h7F, 7'h55, 7'h00, 6);
    expect_frame("blank_invalid", fv0, 1, 16'h800F, 4'b0010, 4'b0100);
`ifdef SEG_SCAN_ERR_COUNT_EN
    checks++;
    if (err_count !== 8'd1) begin
      errors++; $display("FAIL err_one got=%0d exp=1", err_count);
    end
`endif
  endtask

  task automatic test_bad_slots();
    int fv0;
    do_reset();
    fv0 = fv_seen;
    dwell(an_of(0), 7'h79, 6);
    dwell(4'b1100, 7'h24, 20);
    dwell(an_of(1), 7'h24, 6);
    dwell(4'b1111, 7'h30, 20);
    dwell(an_of(2), 7'h30, 6);
    dwell(4'b0000, 7'h19, 20);
    dwell(4'hF, 7'h7F, 3);
    expect_frame("bad_slots_partial", fv0, 0, 16'h0, 4'h0, 4'h0);
    dwell(an_of(3), 7'h19, 6);
    dwell(4'hF, 7'h7F, 3);
    expect_frame("bad_slots", fv0, 1, 16'h4321, 4'h0, 4'h0);
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    dwell(an_of(0), 7'h12, 6); dwell(an_of(1), 7'h02, 6); dwell(an_of(2), 7'h78, 6);
    do_reset();
    fv0 = fv_seen;
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 6);
    expect_frame("reset_mid", fv0, 1, 16'h4321, 4'h0, 4'h0);
    // Reset landing on the edge of the fourth capture must suppress the frame.
    dwell(an_of(0), 7'h12, 6); dwell(an_of(1), 7'h02, 6); dwell(an_of(2), 7'h78, 6);
    dwell(an_of(3), 7'h00, S - 1);
    fv0 = fv_seen;
    do_reset();
    dwell(an_of(0), 7'h12, 6); dwell(an_of(1), 7'h02, 6); dwell(an_of(2), 7'h78, 6);
    dwell(4'hF, 7'h7F, 4);
    expect_frame("reset_on_capture", fv0, 0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic test_long_hold_and_saturation();
    int fv0;
    do_reset();
    fv0 = fv_seen;
    dwell(an_of(0), 7'h10, 100);
    dwell(an_of(1), 7'h08, 6); dwell(an_of(2), 7'h03, 6); dwell(an_of(3), 7'h46, 6);
    dwell(4'hF, 7'h7F, 3);
    expect_frame("long_hold", fv0, 1, 16'hCBA9, 4'h0, 4'h0);
    for (int i = 0; i < 260; i++) dwell(an_of(i % 2), 7'h55, S + 1);
`ifdef SEG_SCAN_ERR_COUNT_EN
    checks++;
    if (err_count !== 8'hFF) begin
      errors++; $display("FAIL err_saturate got=%0d exp=255", err_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] bad_an [4] = '{4'hF, 4'hC, 4'h0, 4'h5};
    logic [3:0] a;
    logic [6:0] s;
    int r;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) a = bad_an[$urandom_range(0, 3)];
      else a = an_of(int'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 9));
      if (r < 8) s = code_tab[$urandom_range(0, 15)];
      else if (r == 8) s = 7'h7F;
      else s = 7'($urandom);
      dwell(a, s, int'($urandom_range(1, 9)));
    end
    dwell(4'hF, 7'h7F, 3);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_blank_invalid();
    test_bad_slots();
    test_reset_mid_frame();
    test_long_hold_and_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
